// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM zeroization engine.
//   zstate_e      : engine states (idle pass-through, write sweep, read sweep, drain)
//   FILL_DEFAULT  : default word written to every location
//   depth_of()    : number of words addressed by an address width
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } zstate_e;

  localparam logic [31:0] FILL_DEFAULT = 32'h0000_0000;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sram_rd_checker.sv
// Read-back compare stage of the zeroization engine.
// A read issued in cycle c (rd_en_i, rd_addr_i) is compared against
// FILL_PATTERN in cycle c+1 using the macro's registered read data.
//   wb_clk_i, rst_i  : clock, asynchronous active-high reset
//   clr_i            : clears fail state at the start of a sweep
//   rd_en_i          : a verify read is presented to the macro this cycle
//   rd_addr_i        : address of that read
//   rd_data_i        : macro port A read data (valid one cycle after the read)
//   fail_o           : sticky mismatch flag
//   fail_addr_o      : address of the first mismatch since clr_i
module sram_rd_checker #(
  parameter int unsigned               SRAM_ADDR_WD = 8,
  parameter int unsigned               SRAM_DATA_WD = 32,
  parameter logic [SRAM_DATA_WD-1:0]   FILL_PATTERN = '0
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    rd_en_i,
  input  logic [SRAM_ADDR_WD-1:0] rd_addr_i,
  input  logic [SRAM_DATA_WD-1:0] rd_data_i,
  output logic                    fail_o,
  output logic [SRAM_ADDR_WD-1:0] fail_addr_o
);

  logic                    vld_q, vld_d;
  logic [SRAM_ADDR_WD-1:0] addr_q, addr_d;
  logic                    fail_q, fail_d;
  logic [SRAM_ADDR_WD-1:0] fail_addr_q, fail_addr_d;

  always_comb begin
    vld_d       = rd_en_i;
    addr_d      = rd_addr_i;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    if (clr_i) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end else if (vld_q && (rd_data_i != FILL_PATTERN)) begin
      fail_d = 1'b1;
      // Only the first mismatch of a sweep is recorded.
      if (!fail_q) fail_addr_d = addr_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q       <= 1'b0;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      vld_q       <= vld_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/sram_zeroize_ctrl.sv
// Secure-memory zeroization engine between the Wishbone SRAM wrapper and a
// dual-port SRAM macro (port B read/write, port A read).
// Idle: wrapper port signals pass straight through to the macro.
// On start_i (or the first clock after reset when AUTO_CLR) the engine owns
// both ports, writes FILL_PATTERN to every word and, when VERIFY_EN, reads
// every word back and records the first mismatching address.
//   wb_clk_i, rst_i           : clock, asynchronous active-high reset
//   start_i                   : single-cycle zeroize request (ignored while busy)
//   up_*_a / up_*_b           : wrapper read port / write port
//   sram_*_a / sram_*_b       : macro port A / port B
//   sram_dout_a               : macro port A read data
//   busy_o                    : engine owns the macro
//   done_o                    : one-cycle pulse in the first idle cycle after a sweep
//   fail_o, fail_addr_o       : sticky verify mismatch and first-fail address
//   drop_o                    : sticky, a wrapper access arrived while busy
module sram_zeroize_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned             SRAM_ADDR_WD = 8,
  parameter int unsigned             SRAM_DATA_WD = 32,
  parameter logic [SRAM_DATA_WD-1:0] FILL_PATTERN = FILL_DEFAULT,
  parameter int unsigned             VERIFY_EN    = 1,
  parameter int unsigned             AUTO_CLR     = 1
) (
  input  logic                      wb_clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      up_csb_a,
  input  logic [SRAM_ADDR_WD-1:0]   up_addr_a,
  input  logic                      up_csb_b,
  input  logic                      up_web_b,
  input  logic [SRAM_DATA_WD/8-1:0] up_mask_b,
  input  logic [SRAM_ADDR_WD-1:0]   up_addr_b,
  input  logic [SRAM_DATA_WD-1:0]   up_din_b,
  output logic                      sram_csb_a,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_a,
  input  logic [SRAM_DATA_WD-1:0]   sram_dout_a,
  output logic                      sram_csb_b,
  output logic                      sram_web_b,
  output logic [SRAM_DATA_WD/8-1:0] sram_mask_b,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_b,
  output logic [SRAM_DATA_WD-1:0]   sram_din_b,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [SRAM_ADDR_WD-1:0]   fail_addr_o,
  output logic                      drop_o
);

  localparam logic [SRAM_ADDR_WD-1:0] PTR_LAST =
    SRAM_ADDR_WD'(depth_of(SRAM_ADDR_WD) - 1);

  zstate_e                 state_q, state_d;
  logic [SRAM_ADDR_WD-1:0] ptr_q, ptr_d;
  logic                    first_q, first_d;
  logic                    done_q, done_d;
  logic                    drop_q, drop_d;
  logic                    go;
  logic                    sweep_start;
  logic                    rd_en;

  // In the first cycle after reset release only AUTO_CLR may start a sweep.
  assign go = first_q ? (AUTO_CLR != 0) : start_i;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    first_d     = 1'b0;
    done_d      = 1'b0;
    drop_d      = drop_q;
    sweep_start = 1'b0;
    rd_en       = 1'b0;

    sram_csb_a  = 1'b1;
    sram_addr_a = ptr_q;
    sram_csb_b  = 1'b1;
    sram_web_b  = 1'b1;
    sram_mask_b = '0;
    sram_addr_b = ptr_q;
    sram_din_b  = FILL_PATTERN;

    unique case (state_q)
      ST_IDLE: begin
        sram_csb_a  = up_csb_a;
        sram_addr_a = up_addr_a;
        sram_csb_b  = up_csb_b;
        sram_web_b  = up_web_b;
        sram_mask_b = up_mask_b;
        sram_addr_b = up_addr_b;
        sram_din_b  = up_din_b;
        if (go) begin
          state_d     = ST_WR;
          ptr_d       = '0;
          drop_d      = 1'b0;
          sweep_start = 1'b1;
        end
      end
      ST_WR: begin
        sram_csb_b  = 1'b0;
        sram_web_b  = 1'b0;
        sram_mask_b = '1;
        ptr_d       = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          if (VERIFY_EN != 0) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RD: begin
        sram_csb_a = 1'b0;
        rd_en      = 1'b1;
        ptr_d      = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && (!up_csb_a || !up_csb_b)) drop_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      first_q <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  sram_rd_checker #(
    .SRAM_ADDR_WD (SRAM_ADDR_WD),
    .SRAM_DATA_WD (SRAM_DATA_WD),
    .FILL_PATTERN (FILL_PATTERN)
  ) u_rd_checker (
    .wb_clk_i    (wb_clk_i),
    .rst_i       (rst_i),
    .clr_i       (sweep_start),
    .rd_en_i     (rd_en),
    .rd_addr_i   (ptr_q),
    .rd_data_i   (sram_dout_a),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o)
  );

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign drop_o = drop_q;

endmodule

// File: tb/tb_sram_zeroize_ctrl.sv
// Scoreboard bench for sram_zeroize_ctrl with a behavioural SRAM macro model.
module tb_sram_zeroize_ctrl;

  localparam logic [31:0] FILL = 32'h0000_0000;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  typedef struct {
    logic       fail;
    logic [7:0] faddr;
    logic       drop;
    int         len;
    int         nwr;
    int         nrd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i, start2;
  logic        up_csb_a, up_csb_b, up_web_b;
  logic [7:0]  up_addr_a, up_addr_b;
  logic [3:0]  up_mask_b;
  logic [31:0] up_din_b;

  logic        sram_csb_a, sram_csb_b, sram_web_b;
  logic [7:0]  sram_addr_a, sram_addr_b;
  logic [3:0]  sram_mask_b;
  logic [31:0] sram_din_b, sram_dout_a;
  logic        busy_o, done_o, fail_o, drop_o;
  logic [7:0]  fail_addr_o;

  logic        csb_a2, csb_b2, web_b2;
  logic [7:0]  addr_a2, addr_b2, fail_addr2;
  logic [3:0]  mask_b2;
  logic [31:0] din_b2;
  logic        busy2, done2, fail2, drop2;

  logic [31:0] mem     [256];
  logic [31:0] mem_ref [256];
  bit          corrupt [256];

  exp_t        sweep_q[$];
  logic [31:0] rd_q[$];
  int          q2[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  always #5 clk = ~clk;

  sram_zeroize_ctrl #(
    .SRAM_ADDR_WD (8),
    .SRAM_DATA_WD (32),
    .FILL_PATTERN (FILL),
    .VERIFY_EN    (1),
    .AUTO_CLR     (1)
  ) dut (
    .wb_clk_i    (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .up_csb_a    (up_csb_a),
    .up_addr_a   (up_addr_a),
    .up_csb_b    (up_csb_b),
    .up_web_b    (up_web_b),
    .up_mask_b   (up_mask_b),
    .up_addr_b   (up_addr_b),
    .up_din_b    (up_din_b),
    .sram_csb_a  (sram_csb_a),
    .sram_addr_a (sram_addr_a),
    .sram_dout_a (sram_dout_a),
    .sram_csb_b  (sram_csb_b),
    .sram_web_b  (sram_web_b),
    .sram_mask_b (sram_mask_b),
    .sram_addr_b (sram_addr_b),
    .sram_din_b  (sram_din_b),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .drop_o      (drop_o)
  );

  sram_zeroize_ctrl #(
    .SRAM_ADDR_WD (8),
    .SRAM_DATA_WD (32),
    .FILL_PATTERN (FILL),
    .VERIFY_EN    (0),
    .AUTO_CLR     (0)
  ) dut_nv (
    .wb_clk_i    (clk),
    .rst_i       (rst_i),
    .start_i     (start2),
    .up_csb_a    (1'b1),
    .up_addr_a   (8'h00),
    .up_csb_b    (1'b1),
    .up_web_b    (1'b1),
    .up_mask_b   (4'h0),
    .up_addr_b   (8'h00),
    .up_din_b    (32'h0),
    .sram_csb_a  (csb_a2),
    .sram_addr_a (addr_a2),
    .sram_dout_a (32'h0),
    .sram_csb_b  (csb_b2),
    .sram_web_b  (web_b2),
    .sram_mask_b (mask_b2),
    .sram_addr_b (addr_b2),
    .sram_din_b  (din_b2),
    .busy_o      (busy2),
    .done_o      (done2),
    .fail_o      (fail2),
    .fail_addr_o (fail_addr2),
    .drop_o      (drop2)
  );

  // Macro model: synchronous read returns pre-write contents; byte-masked writes.
  // Addresses flagged in corrupt[] store BAD instead of the written data.
  initial for (int i = 0; i < 256; i++) mem[i] = $urandom;

  always @(posedge clk) begin
    if (!sram_csb_a) sram_dout_a <= mem[sram_addr_a];
    if (!sram_csb_b && !sram_web_b) begin
      for (int i = 0; i < 4; i++)
        if (sram_mask_b[i]) mem[sram_addr_b][8*i +: 8] <= sram_din_b[8*i +: 8];
      if (corrupt[sram_addr_b]) mem[sram_addr_b] <= BAD;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the verifying instance.
  int   len, wr_exp, rd_exp;
  logic prev_busy, rd_pend;
  always @(negedge clk) begin
    if (rst_i) begin
      len = 0; prev_busy = 1'b0; rd_pend = 1'b0;
    end else begin
      if (busy_o && !prev_busy) begin
        wr_exp = 0; rd_exp = 0;
      end
      if (busy_o) begin
        len++;
        if (!sram_csb_b) begin
          chk("eng_wr_addr", {56'h0, sram_addr_b}, {56'h0, wr_exp[7:0]});
          chk("eng_wr_data", {27'h0, sram_web_b, sram_mask_b, sram_din_b},
              {27'h0, 1'b0, 4'hF, FILL});
          wr_exp++;
        end
        if (!sram_csb_a) begin
          chk("eng_rd_addr", {56'h0, sram_addr_a}, {56'h0, rd_exp[7:0]});
          rd_exp++;
        end
      end else begin
        chk("passthru",
            {9'h0, sram_csb_a, sram_addr_a, sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b},
            {9'h0, up_csb_a, up_addr_a, up_csb_b, up_web_b, up_mask_b, up_addr_b, up_din_b});
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_data: unexpected read data %0h", sram_dout_a);
        end else begin
          chk("rd_data", {32'h0, sram_dout_a}, {32'h0, rd_q.pop_front()});
        end
      end
      rd_pend = !busy_o && !sram_csb_a;
      if (done_o) begin
        done_cnt++;
        if (sweep_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done: unexpected done pulse, got 1 expected 0");
        end else begin
          exp_t e;
          e = sweep_q.pop_front();
          chk("done_busy",  {63'h0, busy_o}, 64'h0);
          chk("busy_len",   64'(len), 64'(e.len));
          chk("fail",       {63'h0, fail_o}, {63'h0, e.fail});
          chk("fail_addr",  {56'h0, fail_addr_o}, {56'h0, e.faddr});
          chk("drop",       {63'h0, drop_o}, {63'h0, e.drop});
          chk("n_writes",   64'(wr_exp), 64'(e.nwr));
          chk("n_reads",    64'(rd_exp), 64'(e.nrd));
        end
        len = 0;
      end
      prev_busy = busy_o;
    end
  end

  // Monitor for the non-verifying instance.
  int len2, alow2;
  always @(negedge clk) begin
    if (rst_i) begin
      len2 = 0; alow2 = 0;
    end else begin
      if (busy2) len2++;
      if (busy2 && !csb_a2) alow2++;
      if (done2) begin
        done2_cnt++;
        if (q2.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL nv_done: unexpected done pulse, got 1 expected 0");
        end else begin
          chk("nv_busy_len", 64'(len2), 64'(q2.pop_front()));
          chk("nv_csb_a_low", 64'(alow2), 64'h0);
        end
        len2 = 0; alow2 = 0;
      end
    end
  end

  task automatic wait_done(input bit second, input int budget);
    int d0;
    d0 = second ? done2_cnt : done_cnt;
    for (int i = 0; i < budget; i++) begin
      if ((second ? done2_cnt : done_cnt) != d0) break;
      tick();
    end
    if ((second ? done2_cnt : done_cnt) == d0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a pulse", budget);
    end
  endtask

  task automatic push_sweep(input logic f, input logic [7:0] fa, input logic d);
    exp_t e;
    e.fail = f; e.faddr = fa; e.drop = d; e.len = 513; e.nwr = 256; e.nrd = 256;
    sweep_q.push_back(e);
  endtask

  task automatic rd(input logic [7:0] a);
    up_csb_a = 1'b0; up_addr_a = a;
    rd_q.push_back(mem_ref[a]);
    tick();
    up_csb_a = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    up_csb_b = 1'b0; up_web_b = 1'b0; up_addr_b = a; up_din_b = d; up_mask_b = m;
    for (int i = 0; i < 4; i++) if (m[i]) mem_ref[a][8*i +: 8] = d[8*i +: 8];
    tick();
    up_csb_b = 1'b1; up_web_b = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic ref_fill();
    for (int i = 0; i < 256; i++) mem_ref[i] = FILL;
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    rst_i = 1'b1; start_i = 1'b0; start2 = 1'b0;
    up_csb_a = 1'b1; up_csb_b = 1'b1; up_web_b = 1'b1;
    up_addr_a = 8'($urandom); up_addr_b = 8'($urandom);
    up_mask_b = 4'($urandom); up_din_b = $urandom;
    for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;

    // Reset state.
    #1;
    chk("rst_status", {59'h0, busy_o, done_o, fail_o, drop_o, 1'b0}, 64'h0);
    chk("rst_fail_addr", {56'h0, fail_addr_o}, 64'h0);
    chk("rst_passthru", {23'h0, sram_addr_b, sram_din_b, sram_csb_b}, {23'h0, up_addr_b, up_din_b, up_csb_b});
    chk("rst_nv_busy", {63'h0, busy2}, 64'h0);

    // Automatic sweep after reset release over random pre-loaded contents.
    push_sweep(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    start_i = 1'b1;        // coincides with release: must be ignored
    rst_i = 1'b0;
    tick();
    start_i = 1'b0;
    chk("auto_busy", {63'h0, busy_o}, 64'h1);
    wait_done(1'b0, 1200);
    ref_fill();
    for (int i = 0; i < 256; i++) rd(8'(i));

    // Corrupted words, dropped write, and an ignored mid-sweep start.
    corrupt[8'h5A] = 1'b1; corrupt[8'hA0] = 1'b1;
    push_sweep(1'b1, 8'h5A, 1'b1);
    pulse_start();
    repeat (48) tick();
    up_csb_b = 1'b0; up_web_b = 1'b0; up_addr_b = 8'h10; up_din_b = 32'h1234_5678; up_mask_b = 4'hF;
    tick();
    up_csb_b = 1'b1; up_web_b = 1'b1;
    repeat (50) tick();
    pulse_start();
    wait_done(1'b0, 1200);
    corrupt[8'h5A] = 1'b0; corrupt[8'hA0] = 1'b0;
    ref_fill();
    mem_ref[8'h5A] = BAD; mem_ref[8'hA0] = BAD;
    rd(8'h10);
    wr(8'h10, 32'h1234_5678, 4'hF);
    rd(8'h10); rd(8'h5A); rd(8'hA0);
    for (int i = 0; i < 16; i++) rd(8'($urandom));

    // Reset mid-sweep.
    pulse_start();
    repeat (299) tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_status", {60'h0, busy_o, done_o, fail_o, drop_o}, 64'h0);
    chk("midrst_fail_addr", {56'h0, fail_addr_o}, 64'h0);
    chk("midrst_passthru", {54'h0, sram_csb_a, sram_csb_b, sram_addr_b}, {54'h0, up_csb_a, up_csb_b, up_addr_b});
    push_sweep(1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    rst_i = 1'b0;
    wait_done(1'b0, 1200);
    repeat (30) tick();
    ref_fill();

    // Random idle traffic.
    for (int i = 0; i < 300; i++) begin
      up_csb_a = 1'($urandom); up_addr_a = 8'($urandom_range(0, 15));
      if (!up_csb_a) rd_q.push_back(mem_ref[up_addr_a]);
      up_csb_b = 1'($urandom); up_web_b = 1'($urandom);
      a = 8'($urandom_range(0, 15)); d = $urandom;
      up_addr_b = a; up_din_b = d; up_mask_b = 4'($urandom);
      if (!up_csb_b && !up_web_b)
        for (int k = 0; k < 4; k++) if (up_mask_b[k]) mem_ref[a][8*k +: 8] = d[8*k +: 8];
      tick();
    end
    up_csb_a = 1'b1; up_csb_b = 1'b1; up_web_b = 1'b1;
    for (int i = 0; i < 16; i++) rd(8'(i));

    // Write-only instance.
    q2.push_back(256);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done(1'b1, 600);

    repeat (5) tick();
    chk("sweep_q_empty", 64'(sweep_q.size()), 64'h0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'h0);
    chk("nv_q_empty", 64'(q2.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
